// File: rtl/store_monitor.sv
// ---------------------------------------------------------------------------
// store_monitor
//
// Passive observer on the core's data-memory write port. Every aligned word
// store that lands inside the result window [BASE_ADDR, BASE_ADDR+4*NUM_WORDS)
// is captured into a show-ahead FIFO. A per-word mask records which window
// words have been written, and done rises once every word has been written.
//
// Optional feature macro: STORE_MON_TIMESTAMP_EN
//   defined   : a 16-bit free-running cycle counter stamps each FIFO entry,
//               and rd_time presents the head entry's stamp
//   undefined : no counter or stamp storage; rd_time is tied to 0
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   MemWrite      core store strobe
//   DataAdr       core store byte address
//   WriteData     core store data
//   rd_en         pop request (ignored while the FIFO is empty)
//   rd_valid      FIFO head valid
//   rd_index      window word index of the head entry
//   rd_data       store data of the head entry
//   rd_time       capture cycle stamp of the head entry
//   fifo_count    FIFO occupancy, 0..FIFO_DEPTH
//   written_mask  bit i set once window word i has been stored
//   done          every window word has been stored (holds until reset)
//   overflow      sticky: an in-window store was dropped on a full FIFO
//   misalign      sticky: an in-window store had DataAdr[1:0] != 0
// ---------------------------------------------------------------------------
module store_monitor #(
  parameter logic [31:0] BASE_ADDR  = 32'd160,
  parameter int          NUM_WORDS  = 20,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        rd_en,
  output logic        rd_valid,
  output logic [4:0]  rd_index,
  output logic [31:0] rd_data,
  output logic [15:0] rd_time,
  output logic [6:0]  fifo_count,
  output logic [31:0] written_mask,
  output logic        done,
  output logic        overflow,
  output logic        misalign
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  DEPTH_C   = 7'(FIFO_DEPTH);
  // 33-bit bounds so the upper limit cannot wrap past 2^32.
  localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI    = WIN_LO + 33'(4 * NUM_WORDS);
  localparam logic [31:0] FULL_MASK = (NUM_WORDS >= 32) ? '1
                                    : 32'((64'd1 << NUM_WORDS) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Store decode
  // ---------------------------------------------------------------------
  logic       in_win;
  logic       hit;
  logic       bad_align;
  logic [4:0] hit_idx;

  assign in_win    = ({1'b0, DataAdr} >= WIN_LO) && ({1'b0, DataAdr} < WIN_HI);
  assign hit       = MemWrite && in_win && (DataAdr[1:0] == 2'b00);
  assign bad_align = MemWrite && in_win && (DataAdr[1:0] != 2'b00);
  assign hit_idx   = 5'((DataAdr - BASE_ADDR) >> 2);

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [6:0]    count_q, count_d;
  logic          fifo_full, fifo_empty;
  logic          do_pop, do_push, drop;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == 7'd0);
  assign do_pop     = rd_en && !fifo_empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts a push.
  assign do_push    = hit && (!fifo_full || do_pop);
  assign drop       = hit && fifo_full && !do_pop;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are log2(FIFO_DEPTH) bits, so they wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage has no reset; an entry is only read while
  // count_q says it is valid, and the head outputs are gated with rd_valid.
  logic [4:0]  idx_mem  [FIFO_DEPTH];
  logic [31:0] data_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (do_push) begin
      idx_mem[wr_ptr_q]  <= hit_idx;
      data_mem[wr_ptr_q] <= WriteData;
    end
  end

  assign rd_valid   = !fifo_empty;
  assign rd_index   = rd_valid ? idx_mem[rd_ptr_q]  : '0;
  assign rd_data    = rd_valid ? data_mem[rd_ptr_q] : '0;
  assign fifo_count = count_q;

`ifdef STORE_MON_TIMESTAMP_EN
  logic [15:0] stamp_q;
  logic [15:0] time_mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stamp_q <= '0;
    else        stamp_q <= stamp_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (do_push) time_mem[wr_ptr_q] <= stamp_q;
  end

  assign rd_time = rd_valid ? time_mem[rd_ptr_q] : '0;
`else
  assign rd_time = '0;
`endif

  // ---------------------------------------------------------------------
  // Written mask and sticky error flags
  // ---------------------------------------------------------------------
  logic [31:0] mask_q, mask_d;
  logic        overflow_q, misalign_q;

  // Re-stores to an already written word leave the mask unchanged; the mask
  // bit is set even when the FIFO drops the entry.
  assign mask_d = mask_q | (hit ? (32'd1 << hit_idx) : 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q     <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      if (drop)      overflow_q <= 1'b1;
      if (bad_align) misalign_q <= 1'b1;
    end
  end

  assign written_mask = mask_q;
  assign overflow     = overflow_q;
  assign misalign     = misalign_q;

  // ---------------------------------------------------------------------
  // Collection FSM with registered done
  // ---------------------------------------------------------------------
  state_t state_q;
  logic   done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A single-word window completes on its first hit.
          if (mask_d == FULL_MASK) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (hit) begin
            state_q <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (mask_d == FULL_MASK) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_store_monitor.sv
// ---------------------------------------------------------------------------
// tb_store_monitor
//
// Self-checking bench for store_monitor with default parameters
// (window 160..239, 20 words, 8-entry FIFO). Directed table vectors and
// hand-written sequences cover the corner cases; a randomized phase is
// compared every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_store_monitor;

  localparam int          BASE  = 160;
  localparam int          NW    = 20;
  localparam int          DEPTH = 8;
  localparam logic [31:0] FULL  = 32'h000F_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [4:0]  rd_index;
  logic [31:0] rd_data;
  logic [15:0] rd_time;
  logic [6:0]  fifo_count;
  logic [31:0] written_mask;
  logic        done;
  logic        overflow;
  logic        misalign;

  always #5 clk = ~clk;

  store_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .DataAdr      (DataAdr),
    .WriteData    (WriteData),
    .rd_en        (rd_en),
    .rd_valid     (rd_valid),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .rd_time      (rd_time),
    .fifo_count   (fifo_count),
    .written_mask (written_mask),
    .done         (done),
    .overflow     (overflow),
    .misalign     (misalign)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: a queue of captured entries plus set-of-words mask
  // -------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic [15:0] t;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_mask;
  bit          m_ovf, m_mis;
  logic [15:0] m_cyc;

  task automatic model_reset();
    mq.delete();
    m_mask = '0;
    m_ovf  = 0;
    m_mis  = 0;
    m_cyc  = '0;
  endtask

  // Applies the rules to the inputs present at the current rising edge.
  task automatic model_edge();
    longint unsigned a;
    bit     in_win, aligned, popped;
    entry_t e;
    a       = longint'(DataAdr);
    in_win  = (a >= BASE) && (a < BASE + 4 * NW);
    aligned = (a % 4) == 0;
    popped  = rd_en && (mq.size() > 0);
    if (popped) void'(mq.pop_front());
    if (MemWrite && in_win && !aligned) m_mis = 1;
    if (MemWrite && in_win && aligned) begin
      e.idx  = 5'((a - BASE) / 4);
      e.data = WriteData;
      e.t    = m_cyc;
      m_mask[e.idx] = 1'b1;
      if (mq.size() < DEPTH) mq.push_back(e);
      else                   m_ovf = 1;
    end
    m_cyc = m_cyc + 16'd1;
  endtask

  function automatic logic [15:0] exp_time(input logic [15:0] t);
`ifdef STORE_MON_TIMESTAMP_EN
    return t;
`else
    return 16'd0 & t;
`endif
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".rd_valid"},   32'(rd_valid),     32'(mq.size() > 0));
    check({tag, ".fifo_count"}, 32'(fifo_count),   32'(mq.size()));
    check({tag, ".mask"},       written_mask,      m_mask);
    check({tag, ".done"},       32'(done),         32'(m_mask == FULL));
    check({tag, ".overflow"},   32'(overflow),     32'(m_ovf));
    check({tag, ".misalign"},   32'(misalign),     32'(m_mis));
    if (mq.size() > 0) begin
      check({tag, ".rd_index"}, 32'(rd_index),     32'(mq[0].idx));
      check({tag, ".rd_data"},  rd_data,           mq[0].data);
      check({tag, ".rd_time"},  32'(rd_time),      32'(exp_time(mq[0].t)));
    end
  endtask

  // Drive inputs now (away from the edge), take one rising edge, then sit
  // 1 time unit after it so outputs can be sampled.
  task automatic cycle(input logic mw, input logic [31:0] adr,
                       input logic [31:0] wd, input logic re);
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = wd;
    rd_en     = re;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asserts reset away from any edge, checks outputs clear without a clock
  // edge, then releases on a falling edge so the next rising edge is cycle 0.
  task automatic apply_reset(input string tag);
    MemWrite = 1'b0;
    rd_en    = 1'b0;
    reset    = 1'b0;
    #1;
    check({tag, ".rst_valid"},    32'(rd_valid),   32'd0);
    check({tag, ".rst_count"},    32'(fifo_count), 32'd0);
    check({tag, ".rst_mask"},     written_mask,    32'd0);
    check({tag, ".rst_flags"},    32'({done, overflow, misalign}), 32'd0);
    check({tag, ".rst_head"},     rd_data | 32'(rd_index) | 32'(rd_time), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        re;
    logic [6:0]  cnt;
    logic        vld;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] mask;
    logic        mis;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [4:0]  exp_idx  [DEPTH];
    logic [31:0] exp_data [DEPTH];

    //            mw    adr      wd            re    cnt   vld   idx    data          mask          mis
    tbl[0]  = '{1'b1, 32'd156, 32'h11,       1'b0, 7'd0, 1'b0, 5'd0,  32'd0,        32'h0,       1'b0};
    tbl[1]  = '{1'b1, 32'd240, 32'h22,       1'b0, 7'd0, 1'b0, 5'd0,  32'd0,        32'h0,       1'b0};
    tbl[2]  = '{1'b1, 32'd162, 32'h33,       1'b0, 7'd0, 1'b0, 5'd0,  32'd0,        32'h0,       1'b1};
    tbl[3]  = '{1'b1, 32'd172, 32'hDEADBEEF, 1'b0, 7'd1, 1'b1, 5'd3,  32'hDEADBEEF, 32'h8,       1'b1};
    tbl[4]  = '{1'b0, 32'd172, 32'h0,        1'b1, 7'd0, 1'b0, 5'd0,  32'd0,        32'h8,       1'b1};
    tbl[5]  = '{1'b1, 32'd160, 32'h5,        1'b1, 7'd1, 1'b1, 5'd0,  32'h5,        32'h9,       1'b1};
    tbl[6]  = '{1'b0, 32'd0,   32'h0,        1'b1, 7'd0, 1'b0, 5'd0,  32'd0,        32'h9,       1'b1};
    tbl[7]  = '{1'b0, 32'd160, 32'h77,       1'b0, 7'd0, 1'b0, 5'd0,  32'd0,        32'h9,       1'b1};
    tbl[8]  = '{1'b1, 32'd236, 32'h7,        1'b0, 7'd1, 1'b1, 5'd19, 32'h7,        32'h80009,   1'b1};
    tbl[9]  = '{1'b1, 32'd159, 32'h99,       1'b0, 7'd1, 1'b1, 5'd19, 32'h7,        32'h80009,   1'b1};
    tbl[10] = '{1'b1, 32'd239, 32'hAA,       1'b0, 7'd1, 1'b1, 5'd19, 32'h7,        32'h80009,   1'b1};

    // ---- table phase --------------------------------------------------
    apply_reset("tbl");
    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      cycle(tbl[i].mw, tbl[i].adr, tbl[i].wd, tbl[i].re);
      check({tag, ".count"},    32'(fifo_count), 32'(tbl[i].cnt));
      check({tag, ".valid"},    32'(rd_valid),   32'(tbl[i].vld));
      check({tag, ".mask"},     written_mask,    tbl[i].mask);
      check({tag, ".misalign"}, 32'(misalign),   32'(tbl[i].mis));
      check({tag, ".ovf_done"}, 32'({overflow, done}), 32'd0);
      if (tbl[i].vld) begin
        check({tag, ".index"}, 32'(rd_index), 32'(tbl[i].idx));
        check({tag, ".data"},  rd_data,       tbl[i].data);
      end
    end

    // ---- fill the whole window with no pops ---------------------------
    apply_reset("fill");
    for (int i = 0; i < NW; i++) begin
      cycle(1'b1, 32'(BASE + 4 * i), 32'(100 + i), 1'b0);
      if (i == 7) begin
        check("fill.count8",   32'(fifo_count), 32'd8);
        check("fill.no_ovf",   32'(overflow),   32'd0);
      end
      if (i == 8) check("fill.ovf_set", 32'(overflow), 32'd1);
      if (i == 18) check("fill.not_done", 32'(done), 32'd0);
    end
    check("fill.count_sat", 32'(fifo_count), 32'd8);
    check("fill.mask",      written_mask,    FULL);
    check("fill.done",      32'(done),       32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("fill.pop%0d.idx", k),  32'(rd_index), 32'(k));
      check($sformatf("fill.pop%0d.data", k), rd_data,       32'(100 + k));
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
    end
    check("fill.drained", 32'({rd_valid, fifo_count}), 32'd0);
    check("fill.done_hold", 32'(done), 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 1'b1);
    check("fill.no_underflow", 32'(fifo_count), 32'd0);

    // ---- full FIFO, push and pop on the same edge ---------------------
    apply_reset("fullpop");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(BASE + 4 * i), 32'(200 + i), 1'b0);
    cycle(1'b1, 32'd200, 32'h0000CAFE, 1'b1);
    check("fullpop.count",    32'(fifo_count), 32'd8);
    check("fullpop.overflow", 32'(overflow),   32'd0);
    for (int k = 0; k < DEPTH - 1; k++) begin
      exp_idx[k]  = 5'(k + 1);
      exp_data[k] = 32'(201 + k);
    end
    exp_idx[DEPTH-1]  = 5'd10;
    exp_data[DEPTH-1] = 32'h0000CAFE;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("fullpop.pop%0d.idx", k),  32'(rd_index), 32'(exp_idx[k]));
      check($sformatf("fullpop.pop%0d.data", k), rd_data,       exp_data[k]);
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
    end
    check("fullpop.empty", 32'(rd_valid), 32'd0);

    // ---- asynchronous reset after 5 captures --------------------------
    apply_reset("mid");
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(BASE + 8 * i), 32'(300 + i), 1'b0);
    cycle(1'b1, 32'd161, 32'd0, 1'b0);
    check("mid.count5",   32'(fifo_count), 32'd5);
    check("mid.misalign", 32'(misalign),   32'd1);
    #2;
    apply_reset("mid_async");

    // ---- timestamps: hits on cycles 3 and 10 after release ------------
    for (int e = 0; e < 12; e++)
      cycle(1'b1 & ((e == 3) || (e == 10)), (e == 3) ? 32'd160 : 32'd164, 32'(e), 1'b0);
    check("ts.count",  32'(fifo_count), 32'd2);
    check("ts.first",  32'(rd_time),    32'(exp_time(16'd3)));
    cycle(1'b0, 32'd0, 32'd0, 1'b1);
    check("ts.second_idx", 32'(rd_index), 32'd1);
    check("ts.second", 32'(rd_time),    32'(exp_time(16'd10)));

    // ---- randomized phase against the reference model -----------------
    apply_reset("rand");
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] adr;
      logic        mw, re;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: adr = 32'(BASE + 4 * $urandom_range(0, NW - 1));
        6:       adr = 32'(BASE + 4 * $urandom_range(0, NW - 1) + $urandom_range(1, 3));
        7:       adr = ($urandom_range(0, 1) != 0) ? 32'd156 : 32'd240;
        8:       adr = $urandom;
        default: adr = 32'hFFFF_FFFC;
      endcase
      mw = ($urandom_range(0, 3) != 0);
      // Pop lightly first so the FIFO saturates, then heavily to drain.
      re = (n < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      cycle(mw, adr, $urandom, re);
      compare_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
